// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM: fetch/decode/exec/mem/writeback sequencing,
// memory handshake with ack timeout, and retired-instruction counting.

package multicycle_ctrl_pkg;
  localparam int W_MEM_CMD = 2;

  localparam logic [W_MEM_CMD-1:0] MEM_NOP   = 2'd0;
  localparam logic [W_MEM_CMD-1:0] MEM_READ  = 2'd1;
  localparam logic [W_MEM_CMD-1:0] MEM_WRITE = 2'd2;

  localparam logic WREN = 1'b1;
  localparam logic WDIS = 1'b0;
endpackage

module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int W_CNT   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic [W_MEM_CMD-1:0] dec_mem_cmd,
  input  logic                 dec_reg_wen,
  input  logic                 dec_halt,
  input  logic                 mem_ack,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic                 addr_sel,
  output logic                 ir_wen,
  output logic                 pc_wen,
  output logic                 reg_wen,
  output logic                 busy,
  output logic                 halted,
  output logic                 err,
  output logic [W_CNT-1:0]     retired
);

  localparam int W_WAIT = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT,
    S_ERR
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [W_WAIT-1:0]  wait_cnt;
  logic [W_WAIT-1:0]  wait_nxt;
  logic [W_CNT-1:0]   retired_q;
  logic               is_write;
  logic               wb_wen;
  logic               req_st;
  logic               timeout;

  // Decoder fields latched in EXEC so MEM/WB outputs depend on state only
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      wait_cnt  <= '0;
      retired_q <= '0;
      is_write  <= 1'b0;
      wb_wen    <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      if (state == S_EXEC) begin
        is_write <= (dec_mem_cmd == MEM_WRITE);
        wb_wen   <= dec_reg_wen;
      end
      if (state == S_WB) begin
        retired_q <= retired_q + W_CNT'(1);
      end
    end
  end

  assign retired = retired_q;
  assign req_st  = (state == S_FETCH) || (state == S_MEM);
  assign timeout = (wait_cnt == W_WAIT'(TIMEOUT - 1));

  // Ack on the timeout cycle takes priority over ERR
  always_comb begin
    wait_nxt = '0;
    if (req_st && !mem_ack && !timeout) begin
      wait_nxt = wait_cnt + W_WAIT'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    addr_sel  = 1'b0;
    ir_wen    = 1'b0;
    pc_wen    = 1'b0;
    reg_wen   = 1'b0;
    busy      = 1'b0;
    halted    = 1'b0;
    err       = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (run) begin
          state_nxt = S_FETCH;
        end
      end
      S_FETCH: begin
        busy    = 1'b1;
        mem_req = 1'b1;
        if (mem_ack) begin
          ir_wen    = 1'b1;
          state_nxt = S_DECODE;
        end else if (timeout) begin
          state_nxt = S_ERR;
        end
      end
      S_DECODE: begin
        busy      = 1'b1;
        state_nxt = dec_halt ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        busy = 1'b1;
        if (dec_mem_cmd == MEM_NOP) begin
          state_nxt = S_WB;
        end else begin
          state_nxt = S_MEM;
        end
      end
      S_MEM: begin
        busy     = 1'b1;
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        mem_we   = is_write;
        if (mem_ack) begin
          state_nxt = S_WB;
        end else if (timeout) begin
          state_nxt = S_ERR;
        end
      end
      S_WB: begin
        busy      = 1'b1;
        pc_wen    = 1'b1;
        reg_wen   = wb_wen;
        state_nxt = S_FETCH;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      S_ERR: begin
        err = 1'b1;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-instruction schedule model builds
// stimulus and expected outputs, checked every cycle plus literal pins.

module tb_multicycle_ctrl;
  import multicycle_ctrl_pkg::*;

  localparam int CW = 3;
  localparam int TO = 4;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 run = 1'b0;
  logic [W_MEM_CMD-1:0] dec_mem_cmd = '0;
  logic                 dec_reg_wen = 1'b0;
  logic                 dec_halt = 1'b0;
  logic                 mem_ack = 1'b0;
  logic                 mem_req, mem_we, addr_sel;
  logic                 ir_wen, pc_wen, reg_wen;
  logic                 busy, halted, err;
  logic [CW-1:0]        retired;

  multicycle_ctrl #(.W_CNT(CW), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .dec_mem_cmd (dec_mem_cmd),
    .dec_reg_wen (dec_reg_wen),
    .dec_halt    (dec_halt),
    .mem_ack     (mem_ack),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .addr_sel    (addr_sel),
    .ir_wen      (ir_wen),
    .pc_wen      (pc_wen),
    .reg_wen     (reg_wen),
    .busy        (busy),
    .halted      (halted),
    .err         (err),
    .retired     (retired)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic rst, run, ack, halt, wen;
    logic [W_MEM_CMD-1:0] cmd;
  } in_t;

  typedef struct packed {
    logic req, we, asel, ir, pc, rw, busy, halted, err;
    logic [CW-1:0] ret;
  } out_t;

  in_t        stim_q[$];
  out_t       exp_q[$];
  logic [8:0] lit_bits[int];
  int         lit_ret[int];
  int         m_ret = 0;
  int         n_vec = 0;
  int         n_bad = 0;

  function automatic out_t o_base();
    out_t o;
    o = '0;
    o.ret = CW'(m_ret);
    return o;
  endfunction

  // Inputs that must be ignored outside their sampling state
  function automatic in_t i_noise();
    in_t i;
    i.rst  = 1'b1;
    i.run  = 1'b0;
    i.ack  = 1'b1;
    i.halt = 1'b1;
    i.wen  = 1'b1;
    i.cmd  = MEM_WRITE;
    return i;
  endfunction

  task automatic emit(input in_t i, input out_t o);
    stim_q.push_back(i);
    exp_q.push_back(o);
  endtask

  task automatic pin(input int idx, input logic [8:0] b, input int r);
    lit_bits[idx] = b;
    lit_ret[idx]  = r;
  endtask

  task automatic do_reset(input int n);
    in_t i;
    m_ret = 0;
    for (int c = 0; c < n; c++) begin
      i = i_noise();
      i.rst = 1'b0;
      i.run = 1'b1;
      emit(i, o_base());
    end
  endtask

  task automatic idle(input logic r);
    in_t i;
    i = i_noise();
    i.run = r;
    emit(i, o_base());
  endtask

  task automatic instr(input logic [W_MEM_CMD-1:0] cmd, input logic wen,
                       input logic halt, input int fd, input int md,
                       input int abort = -1);
    in_t  i;
    out_t o;
    for (int c = 0; c <= fd && c < TO; c++) begin
      i = i_noise();
      i.ack = (c == fd);
      o = o_base();
      o.req  = 1'b1;
      o.ir   = (c == fd);
      o.busy = 1'b1;
      emit(i, o);
    end
    if (fd >= TO) return;
    i = i_noise();
    i.run  = 1'b1;
    i.cmd  = cmd;
    i.wen  = wen;
    i.halt = halt;
    o = o_base();
    o.busy = 1'b1;
    emit(i, o);
    if (halt) return;
    i.halt = 1'b1;
    emit(i, o);
    if (cmd != MEM_NOP) begin
      for (int c = 0; c <= md && c < TO; c++) begin
        if (c == abort) return;
        i.ack = (c == md);
        o = o_base();
        o.req  = 1'b1;
        o.asel = 1'b1;
        o.we   = (cmd == MEM_WRITE);
        o.busy = 1'b1;
        emit(i, o);
      end
      if (md >= TO) return;
    end
    i.ack = 1'b1;
    o = o_base();
    o.pc   = 1'b1;
    o.rw   = wen;
    o.busy = 1'b1;
    emit(i, o);
    m_ret = (m_ret + 1) % (1 << CW);
  endtask

  task automatic term(input logic is_err, input int n);
    in_t  i;
    out_t o;
    for (int c = 0; c < n; c++) begin
      i = i_noise();
      i.run = c[0];
      i.ack = c[1];
      o = o_base();
      o.halted = !is_err;
      o.err    = is_err;
      emit(i, o);
    end
  endtask

  task automatic check(input int k);
    out_t got;
    got = {mem_req, mem_we, addr_sel, ir_wen, pc_wen, reg_wen,
           busy, halted, err, retired};
    n_vec++;
    if (got !== exp_q[k]) begin
      n_bad++;
      $display("FAIL vec%0d outputs: got %b expected %b", k, got, exp_q[k]);
    end
    if (lit_bits.exists(k)) begin
      n_vec++;
      if (got[CW+8:CW] !== lit_bits[k] || got.ret !== CW'(lit_ret[k])) begin
        n_bad++;
        $display("FAIL vec%0d pinned: got %b/%0d expected %b/%0d",
                 k, got[CW+8:CW], got.ret, lit_bits[k], lit_ret[k]);
      end
    end
  endtask

  initial begin
    int b;
    // Reset, idle hold, ADD / LW / SW and ack-delay boundaries
    do_reset(2);
    idle(1'b0);
    idle(1'b0);
    b = stim_q.size();
    idle(1'b1);
    instr(MEM_NOP, WREN, 1'b0, 0, 0);
    pin(b + 1, 9'b100100100, 0);
    pin(b + 4, 9'b000011100, 0);
    instr(MEM_READ, WREN, 1'b0, 0, 3);
    pin(b + 5, 9'b100100100, 1);
    pin(b + 8, 9'b101000100, 1);
    pin(b + 11, 9'b101000100, 1);
    pin(b + 12, 9'b000011100, 1);
    instr(MEM_WRITE, WDIS, 1'b0, 1, 0);
    pin(b + 17, 9'b111000100, 2);
    pin(b + 18, 9'b000010100, 2);
    instr(MEM_NOP, WDIS, 1'b0, 3, 0);
    instr(MEM_READ, WREN, 1'b0, 2, 3);
    for (int n = 0; n < 4; n++) instr(MEM_NOP, WREN, 1'b0, n % 3, 0);
    // Counter has wrapped to 1; reset lands mid-MEM
    instr(MEM_READ, WREN, 1'b0, 0, 3, 2);
    b = stim_q.size();
    pin(b - 1, 9'b101000100, 1);
    pin(b, 9'b000000000, 0);
    do_reset(2);
    idle(1'b1);
    instr(MEM_NOP, WREN, 1'b0, 0, 0);
    pin(b + 6, 9'b000011100, 0);
    b = stim_q.size();
    instr(MEM_NOP, WREN, 1'b0, TO, 0);
    pin(b + 3, 9'b100000100, 1);
    pin(b + 4, 9'b000000001, 1);
    term(1'b1, 6);
    // Halt after two retired instructions
    do_reset(2);
    idle(1'b1);
    instr(MEM_NOP, WREN, 1'b0, 0, 0);
    instr(MEM_WRITE, WDIS, 1'b0, 0, 1);
    b = stim_q.size();
    instr(MEM_NOP, WREN, 1'b1, 1, 0);
    pin(b + 2, 9'b000000100, 2);
    pin(b + 3, 9'b000000010, 2);
    term(1'b0, 5);
    // Timeout while waiting in MEM
    do_reset(1);
    idle(1'b1);
    b = stim_q.size();
    instr(MEM_READ, WREN, 1'b0, 0, 9);
    pin(b + 6, 9'b101000100, 0);
    pin(b + 7, 9'b000000001, 0);
    term(1'b1, 4);

    for (int k = 0; k < stim_q.size(); k++) begin
      @(posedge clk);
      #1;
      {rst, run, mem_ack, dec_halt, dec_reg_wen, dec_mem_cmd} = stim_q[k];
      @(negedge clk);
      check(k);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL have parameter W_CNT, default 32, giving the width of the retired-instruction counter.
REQ-002 The block SHALL have parameter TIMEOUT, default 255, giving the maximum number of cycles a memory request waits for ack.
REQ-003 The block SHALL have one clock and asynchronous active-low reset: clk in 1, rising-edge clock; rst in 1, asynchronous active-low reset.
REQ-004 run  in  1  start request; sampled only in IDLE.
REQ-005 dec_mem_cmd  in  W_MEM_CMD  decoder memory command (MEM_NOP/MEM_READ/MEM_WRITE).
REQ-006 dec_reg_wen  in  1  decoder register write enable (WREN/WDIS).
REQ-007 dec_halt  in  1  decoder flags a halting syscall; sampled in DECODE.
REQ-008 mem_ack  in  1  memory completes the current request this cycle.
REQ-009 mem_req  out  1  memory request, held until ack.
REQ-010 mem_we  out  1  memory write qualifier, valid only while mem_req=1.
REQ-011 addr_sel  out  1  memory address mux: 0=PC, 1=ALU result.
REQ-012 ir_wen, pc_wen, reg_wen  out  1 each  single-cycle write strobes for IR, PC, register file.
REQ-013 busy  out  1  high in every state except IDLE, HALT, ERR.
REQ-014 halted, err  out  1 each  sticky status flags.
REQ-015 retired  out  W_CNT  count of completed instructions.

Function
REQ-016 The block SHALL implement states IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT, ERR, all registered; outputs SHALL be decoded from registered state plus mem_ack only.
REQ-017 IDLE: all strobes low; run=1 -> FETCH next cycle, else stay.
REQ-018 FETCH: mem_req=1, mem_we=0, addr_sel=0; on mem_ack=1 assert ir_wen that same cycle and go to DECODE.
REQ-019 DECODE: one cycle, no strobes; dec_halt=1 -> HALT, else -> EXEC.
REQ-020 EXEC: one cycle, no strobes; dec_mem_cmd=MEM_NOP -> WB, otherwise -> MEM.
REQ-021 MEM: mem_req=1, addr_sel=1, mem_we=1 iff dec_mem_cmd=MEM_WRITE; on mem_ack=1 go to WB.
REQ-022 WB: one cycle; pc_wen=1; reg_wen=dec_reg_wen; retired increments by 1; next state FETCH.
REQ-023 Instruction latency SHALL be 4 cycles (no memory op) or 5 cycles (memory op) with mem_ack returned in the first request cycle; each cycle of ack delay adds one cycle.
REQ-024 A wait counter SHALL clear on entry to FETCH/MEM and increment each request cycle without ack; reaching TIMEOUT cycles without ack -> ERR, with mem_req dropped the following cycle.
REQ-025 mem_ack outside FETCH/MEM SHALL be ignored; mem_ack in the cycle the timeout fires SHALL win (normal transition, no ERR).
REQ-026 HALT and ERR SHALL be terminal: all strobes low, halted=1 in HALT, err=1 in ERR; exit only via reset; run ignored.
REQ-027 retired SHALL wrap from all-ones to 0 without flag; HALT instruction SHALL NOT count.
REQ-028 ir_wen, pc_wen, reg_wen SHALL never be high in the same cycle, and each SHALL be high at most once per instruction.

Reset
REQ-029 rst=0 SHALL asynchronously force state IDLE, wait counter 0, retired 0, and all outputs 0, including mid-request (mem_req drops immediately without waiting for ack).
REQ-030 After rst rises, the first possible state change SHALL be IDLE->FETCH at the next clk edge with run=1.

Verification
REQ-031 Reset, run=1, ack every request cycle, ADD-like instr (MEM_NOP, WREN) -> ir_wen cycle 1, pc_wen+reg_wen cycle 4, retired=1.
REQ-032 LW (MEM_READ, WREN), ack delayed 3 cycles in MEM -> mem_req high 4 cycles with mem_we=0, addr_sel=1, WB at cycle 8, reg_wen=1.
REQ-033 SW (MEM_WRITE, WDIS) -> mem_we=1 during MEM, WB has pc_wen=1, reg_wen=0.
REQ-034 TIMEOUT=4, no ack in FETCH -> ERR after 4 request cycles, err=1, busy=0, mem_req=0; run toggling has no effect.
REQ-035 dec_halt=1 in DECODE after 2 normal instructions -> halted=1, retired=2, no pc_wen for halting instr.
REQ-036 rst asserted mid-MEM with mem_req=1 -> all outputs 0 immediately; re-run restarts at FETCH with retired=0.
